// File: rtl/exp_pkg.sv
// Shared types and constants for the Q8.8 exp(x) Taylor-series controller.
package exp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMulx,
    StMulq,
    StAcc,
    StDone
  } state_e;

  localparam logic [15:0] ONE_Q8    = 16'h0100;
  localparam int unsigned Q_FRAC    = 8;
  localparam int unsigned ROM_DEPTH = 12;

endpackage

// File: rtl/sat_mul_q8.sv
// Unsigned Q8.8 multiply: full product, drop the fraction bits, clamp to all-ones on overflow.
module sat_mul_q8
  import exp_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] p_o,
  output logic              ovf_o
);

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] shifted;

  always_comb begin
    prod    = a_i * b_i;
    shifted = prod >> Q_FRAC;
    ovf_o   = |shifted[2*DATA_W-1:DATA_W];
    p_o     = ovf_o ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/exp_taylor_ctrl.sv
// Iterative exp(x) in Q8.8: acc = 1 + sum of x^n/n! using an external 1/(n+1) ROM.
// Define EXP_EARLY_EXIT_EN to finish as soon as a term truncates to zero.
module exp_taylor_ctrl
  import exp_pkg::*;
#(
  parameter int unsigned N_TERMS = 12,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] x,
  output logic [3:0]        rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] term_q, term_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        idx_q, idx_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_p;
  logic              mul_ovf;
  logic [DATA_W:0]   sum;
  logic              last;

  // One multiplier serves both steps; the operand mux picks x or 1/(n+1).
  assign mul_b = (state_q == StMulq) ? rom_data : x_q;

  sat_mul_q8 #(
    .DATA_W(DATA_W)
  ) u_mul (
    .a_i  (term_q),
    .b_i  (mul_b),
    .p_o  (mul_p),
    .ovf_o(mul_ovf)
  );

  assign sum = {1'b0, acc_q} + {1'b0, term_q};

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    term_d   = term_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    last     = (idx_q == 4'(N_TERMS - 1));
`ifdef EXP_EARLY_EXIT_EN
    last     = last || (term_q == '0);
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x;
          term_d  = DATA_W'(ONE_Q8);
          acc_d   = DATA_W'(ONE_Q8);
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = StMulx;
        end
      end
      StMulx: begin
        term_d  = mul_p;
        ovf_d   = ovf_q | mul_ovf;
        state_d = StMulq;
      end
      StMulq: begin
        term_d  = mul_p;
        ovf_d   = ovf_q | mul_ovf;
        state_d = StAcc;
      end
      StAcc: begin
        acc_d = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        ovf_d = ovf_q | sum[DATA_W];
        if (last) begin
          result_d = acc_d;
          state_d  = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StMulx;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      term_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rom_addr = idx_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign result   = result_q;
  assign ovf      = ovf_q;

endmodule
